// File: rtl/core_pkg.sv
// Shared core constants and the fetch state encoding.
package core_pkg;

   localparam int unsigned XLEN    = 32;
   localparam int unsigned PC_STEP = 4;

   typedef enum logic [1:0] {
      BOOT = 2'd0,
      RUN  = 2'd1,
      HALT = 2'd2
   } fetch_state_e;

endpackage

// File: rtl/pc_fetch_unit_flush_counter.sv
// Loadable down-counter that holds the front-end flush high for FLUSH_DEPTH cycles.
module flush_counter #(
   parameter int unsigned FLUSH_DEPTH = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic load,
   output logic active,
   output logic active_next
);

   localparam int unsigned CW = 3;

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = CW'(FLUSH_DEPTH);
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - CW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign active      = (cnt_q != '0);
   // Lets the fetch path suppress if_valid for a cycle that will already be flushed.
   assign active_next = (cnt_d != '0);

endmodule

// File: rtl/pc_fetch_unit.sv
// Program counter owner: imem fetch handshake, branch redirect, flush and misaligned-target halt.
module pc_fetch_unit
   import core_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC    = 32'h0000_0000,
   parameter int unsigned     FLUSH_DEPTH = 2
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            ex_valid,
   input  logic            ex_taken,
   input  logic [XLEN-1:0] ex_target,
   input  logic            stall,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_ready,
   output logic            if_valid,
   output logic [XLEN-1:0] if_pc,
   output logic [XLEN-1:0] if_pc_plus4,
   output logic            flush,
   output logic            misaligned,
   output logic [XLEN-1:0] misaligned_pc
);

   fetch_state_e    state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic [XLEN-1:0] if_pc_q, if_pc_d;
   logic [XLEN-1:0] if_pc_plus4_q, if_pc_plus4_d;
   logic [XLEN-1:0] mis_pc_q, mis_pc_d;
   logic            if_valid_q, if_valid_d;
   logic            mis_q, mis_d;

   logic handshake, take, bad_target, redirect, flush_next;

   assign imem_req   = (state_q == RUN) && !stall;
   assign imem_addr  = pc_q;
   assign handshake  = imem_req && imem_ready;
   assign take       = (state_q == RUN) && ex_valid && ex_taken;
   assign bad_target = take && (ex_target[1:0] != 2'b00);
   assign redirect   = take && !bad_target;

   flush_counter #(
      .FLUSH_DEPTH (FLUSH_DEPTH)
   ) u_flush_counter (
      .clk         (clk),
      .rst_n       (rst_n),
      .load        (take),
      .active      (flush),
      .active_next (flush_next)
   );

   always_comb begin
      state_d       = state_q;
      pc_d          = pc_q;
      if_valid_d    = 1'b0;
      if_pc_d       = if_pc_q;
      if_pc_plus4_d = if_pc_plus4_q;
      mis_d         = 1'b0;
      mis_pc_d      = mis_pc_q;

      unique case (state_q)
         BOOT: state_d = RUN;
         RUN: begin
            // A taken branch squashes any handshake in the same cycle.
            if (bad_target) begin
               mis_d    = 1'b1;
               mis_pc_d = ex_target;
               state_d  = HALT;
            end else if (redirect) begin
               pc_d = ex_target;
            end else if (handshake) begin
               pc_d = pc_q + XLEN'(PC_STEP);
               if (!flush_next) begin
                  if_valid_d    = 1'b1;
                  if_pc_d       = pc_q;
                  if_pc_plus4_d = pc_q + XLEN'(PC_STEP);
               end
            end
         end
         HALT: state_d = HALT;
         default: state_d = BOOT;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= BOOT;
         pc_q          <= RESET_PC;
         if_valid_q    <= 1'b0;
         if_pc_q       <= '0;
         if_pc_plus4_q <= '0;
         mis_q         <= 1'b0;
         mis_pc_q      <= '0;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         if_valid_q    <= if_valid_d;
         if_pc_q       <= if_pc_d;
         if_pc_plus4_q <= if_pc_plus4_d;
         mis_q         <= mis_d;
         mis_pc_q      <= mis_pc_d;
      end
   end

   assign if_valid      = if_valid_q;
   assign if_pc         = if_pc_q;
   assign if_pc_plus4   = if_pc_plus4_q;
   assign misaligned    = mis_q;
   assign misaligned_pc = mis_pc_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Randomized scoreboard bench for pc_fetch_unit against a cycle-level behavioural model.
module tb_pc_fetch_unit;

   localparam logic [31:0] RST_PC = 32'h0000_0100;
   localparam int          DEPTH  = 2;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        ex_valid = 1'b0;
   logic        ex_taken = 1'b0;
   logic [31:0] ex_target = '0;
   logic        stall = 1'b0;
   logic        imem_ready = 1'b0;
   logic        imem_req, if_valid, flush, misaligned;
   logic [31:0] imem_addr, if_pc, if_pc_plus4, misaligned_pc;

   pc_fetch_unit #(
      .RESET_PC    (RST_PC),
      .FLUSH_DEPTH (DEPTH)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .ex_valid      (ex_valid),
      .ex_taken      (ex_taken),
      .ex_target     (ex_target),
      .stall         (stall),
      .imem_req      (imem_req),
      .imem_addr     (imem_addr),
      .imem_ready    (imem_ready),
      .if_valid      (if_valid),
      .if_pc         (if_pc),
      .if_pc_plus4   (if_pc_plus4),
      .flush         (flush),
      .misaligned    (misaligned),
      .misaligned_pc (misaligned_pc)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] pc;
      int          cyc;
   } exp_t;

   exp_t        exp_q[$];
   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;

   // Model: mode 0 = booting, 1 = fetching, 2 = halted.
   int          m_mode;
   logic [31:0] m_pc;
   logic [31:0] m_mis_pc;
   int          m_flush;
   bit          m_mis;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h want %h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   task automatic model_reset();
      m_mode   = 0;
      m_pc     = RST_PC;
      m_flush  = 0;
      m_mis    = 1'b0;
      m_mis_pc = '0;
      exp_q.delete();
   endtask

   task automatic model_edge();
      bit   take, bad, redir, hs;
      exp_t e;
      if (!rst_n) return;
      take  = (m_mode == 1) && ex_valid && ex_taken;
      bad   = take && ((ex_target % 4) != 0);
      redir = take && !bad;
      hs    = (m_mode == 1) && !stall && imem_ready;
      if (m_flush > 0) m_flush--;
      if (take) m_flush = DEPTH;
      m_mis = bad;
      if (bad) begin
         m_mis_pc = ex_target;
         m_mode   = 2;
      end else if (redir) begin
         m_pc = ex_target;
      end else if (hs) begin
         if (m_flush == 0) begin
            e.pc  = m_pc;
            e.cyc = cyc + 1;
            exp_q.push_back(e);
         end
         m_pc = m_pc + 32'd4;
      end
      if (m_mode == 0) m_mode = 1;
   endtask

   task automatic step(input bit v, input bit t, input logic [31:0] tgt, input bit st, input bit rdy);
      @(negedge clk);
      ex_valid   = v;
      ex_taken   = t;
      ex_target  = tgt;
      stall      = st;
      imem_ready = rdy;
      #1;
      if (rst_n) begin
         chk("imem_req", 32'(imem_req), 32'(m_mode == 1 && !st));
         chk("imem_addr", imem_addr, m_pc);
      end
      @(posedge clk);
      model_edge();
      cyc++;
   endtask

   task automatic do_reset();
      @(negedge clk);
      ex_valid = 1'b0;
      chk("pre_reset_imem_req", 32'(imem_req), 32'(m_mode == 1 && !stall));
      #3;
      rst_n = 1'b0;
      model_reset();
      #1;
      chk("rst_imem_req", 32'(imem_req), 32'd0);
      chk("rst_imem_addr", imem_addr, RST_PC);
      chk("rst_if_valid", 32'(if_valid), 32'd0);
      chk("rst_if_pc", if_pc, 32'd0);
      chk("rst_if_pc_plus4", if_pc_plus4, 32'd0);
      chk("rst_flush", 32'(flush), 32'd0);
      chk("rst_misaligned", 32'(misaligned), 32'd0);
      chk("rst_misaligned_pc", misaligned_pc, 32'd0);
      repeat (2) step(0, 0, 32'h0, 0, 1);
      #2 rst_n = 1'b1;
   endtask

   task automatic random_phase(input int n);
      bit          v, t, st, rdy;
      logic [31:0] tgt;
      for (int i = 0; i < n; i++) begin
         v   = ($urandom_range(0, 5) == 0);
         t   = $urandom_range(0, 1) != 0;
         tgt = $urandom() & 32'hFFFF_FFFC;
         if (!t && $urandom_range(0, 1) != 0) tgt = tgt | 32'h2;
         st  = ($urandom_range(0, 3) == 0);
         rdy = ($urandom_range(0, 3) != 0);
         step(v, t, tgt, st, rdy);
      end
   endtask

   // Scoreboard monitor: registered outputs sampled on the falling edge.
   always @(negedge clk) begin
      exp_t e;
      bit   exp_v;
      chk("flush", 32'(flush), 32'(m_flush > 0));
      chk("misaligned", 32'(misaligned), 32'(m_mis));
      chk("misaligned_pc", misaligned_pc, m_mis_pc);
      exp_v = (exp_q.size() > 0) && (exp_q[0].cyc == cyc);
      chk("if_valid", 32'(if_valid), 32'(exp_v));
      if (exp_v) begin
         e = exp_q.pop_front();
         if (if_valid === 1'b1) begin
            chk("if_pc", if_pc, e.pc);
            chk("if_pc_plus4", if_pc_plus4, e.pc + 32'd4);
         end
      end
   end

   initial begin
      model_reset();
      repeat (3) step(0, 0, 32'h0, 0, 1);
      #2 rst_n = 1'b1;

      // Boot then streaming fetch from RESET_PC.
      repeat (5) step(0, 0, 32'h0, 0, 1);

      // Redirect to 0x200 and hold imem_ready low for three cycles there.
      step(1, 1, 32'h0000_0200, 0, 1);
      repeat (3) step(0, 0, 32'h0, 0, 0);
      repeat (3) step(0, 0, 32'h0, 0, 1);

      // Redirect coinciding with the handshake at 0x20C, then a second redirect during flush.
      step(1, 1, 32'h0000_0400, 0, 1);
      step(0, 0, 32'h0, 0, 1);
      step(1, 1, 32'h0000_0500, 0, 1);
      repeat (4) step(0, 0, 32'h0, 0, 1);

      // Not-taken resolutions have no effect, even with a misaligned target.
      step(1, 0, 32'h0000_040C, 0, 1);
      step(1, 0, 32'h0000_0003, 0, 1);

      // PC wrap and redirect under stall.
      step(1, 1, 32'hFFFF_FFF8, 0, 1);
      repeat (4) step(0, 0, 32'h0, 0, 1);
      step(0, 0, 32'h0, 1, 1);
      step(1, 1, 32'h0000_0300, 1, 1);
      step(0, 0, 32'h0, 1, 1);
      repeat (3) step(0, 0, 32'h0, 0, 1);

      random_phase(300);

      // Misaligned target halts the unit; later redirects are ignored.
      step(1, 1, 32'h0000_0402, 0, 1);
      repeat (2) step(0, 0, 32'h0, 0, 1);
      step(1, 1, 32'h0000_0600, 0, 1);
      repeat (4) step(0, 0, 32'h0, 0, 1);

      do_reset();
      repeat (6) step(0, 0, 32'h0, 0, 1);

      // Reset while a request is outstanding and imem is not ready.
      repeat (2) step(0, 0, 32'h0, 0, 0);
      do_reset();
      repeat (6) step(0, 0, 32'h0, 0, 1);

      random_phase(200);
      repeat (3) step(0, 0, 32'h0, 0, 0);
      chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
